// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the memory-mapped UART receiver.
//   - register word indices on the 0xffff07xx page
//   - STATUS / DATA / CTRL bit positions
//   - receive FSM state encoding and FIFO entry width
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

  localparam logic [5:0] REG_DATA   = 6'd8;
  localparam logic [5:0] REG_STATUS = 6'd9;
  localparam logic [5:0] REG_CTRL   = 6'd10;

  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_OVR   = 18;
  localparam int unsigned STAT_FERR  = 19;
  localparam int unsigned STAT_PERR  = 20;

  localparam int unsigned DATA_VALID = 8;
  localparam int unsigned DATA_PERR  = 9;

  localparam int unsigned CTRL_CLR_OVR  = 0;
  localparam int unsigned CTRL_CLR_FERR = 1;
  localparam int unsigned CTRL_CLR_PERR = 2;
  localparam int unsigned CTRL_FLUSH    = 3;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned ENTRY_W = 9;
`else
  localparam int unsigned ENTRY_W = 8;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_mem_sync_fifo.sv
// sync_fifo: single-clock FIFO with push, pop and flush.
//   clk, rst      : clock, async active-high reset
//   push/din      : write an entry (ignored when full or flushing)
//   pop           : drop the head entry (ignored when empty or flushing)
//   flush         : empty the FIFO; beats a simultaneous push/pop
//   head          : current head entry
//   count/empty/full : occupancy
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty differ at wrap-around.
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                wr_en_c;
  logic                rd_en_c;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == FULL_CNT);
  assign head    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign wr_en_c = push && !full && !flush;
  assign rd_en_c = pop && !empty && !flush;

  // Pointer update; flush resets both pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en_c) wr_ptr_d = wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array needs no reset: an entry is only read after it is written.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx_mem.sv
// uart_rx_mem: memory-mapped 8N1 UART receiver with a receive FIFO.
//   clk, rst  : system clock, async active-high reset
//   rx        : asynchronous serial input, idles high
//   writeb    : byte write strobes (page-qualified)
//   read      : read strobe (page-qualified)
//   addr      : word address (dmem_addr[7:2])
//   wdata     : write data
//   rdata     : registered read data, valid the cycle after read
// Registers: 8 DATA (pop on read), 9 STATUS, 10 CTRL (write clears/flush).
// Optional feature macro: UART_RX_PARITY_EN (even parity, PERR flag, 9-bit entries).
module uart_rx_mem
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 625,
  parameter int unsigned DEPTH_LOG2   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [3:0]  writeb,
  input  logic        read,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);

  // Synchroniser
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;

  // Receive FSM
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             wait_high_q, wait_high_d;

  // Sticky flags and read data
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic [31:0] rdata_q, rdata_d;

  logic push_c, ovr_set_c, ferr_set_c;
  logic rd_data_c, ctrl_wr_c, pop_c, flush_c;
  logic [ENTRY_W-1:0]  push_data_c;
  logic [ENTRY_W-1:0]  head;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                fifo_empty, fifo_full;
  logic                unused_c;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  logic perr_q, perr_d;
  logic perr_set_c;
  assign push_data_c = {par_err_q, shift_q};
`else
  assign push_data_c = shift_q;
`endif

  assign rd_data_c = read && (addr == REG_DATA);
  assign ctrl_wr_c = writeb[0] && (addr == REG_CTRL);
  assign pop_c     = rd_data_c && !fifo_empty;
  assign flush_c   = ctrl_wr_c && wdata[CTRL_FLUSH];
  assign rdata     = rdata_q;
  assign unused_c  = ^{writeb[3:1], wdata[31:4], wdata[2]};

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .flush (flush_c),
    .din   (push_data_c),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Receive FSM next-state: sample mid-bit, LSB first.
  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    push_c      = 1'b0;
    ovr_set_c   = 1'b0;
    ferr_set_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
    perr_set_c  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_sync_q) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          // A high line at mid-start is a glitch.
          state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          par_err_d  = rx_sync_q != (^shift_q);
          perr_set_c = rx_sync_q != (^shift_q);
          state_d    = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (wait_high_q) begin
          // After a framing error, hold off until the line is idle again.
          if (rx_sync_q) begin
            wait_high_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            push_c    = !fifo_full;
            ovr_set_c = fifo_full;
            state_d   = ST_IDLE;
          end else begin
            ferr_set_c  = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_comb begin
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (ctrl_wr_c && wdata[CTRL_CLR_OVR])  ovr_d  = 1'b0;
    if (ctrl_wr_c && wdata[CTRL_CLR_FERR]) ferr_d = 1'b0;
    if (ovr_set_c)  ovr_d  = 1'b1;
    if (ferr_set_c) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
    perr_d = perr_q;
    if (ctrl_wr_c && wdata[CTRL_CLR_PERR]) perr_d = 1'b0;
    if (perr_set_c) perr_d = 1'b1;
`endif
  end

  // Read data mux, captured on the read cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      rdata_d = '0;
      case (addr)
        REG_DATA: begin
          if (!fifo_empty) begin
            rdata_d[7:0]        = head[7:0];
            rdata_d[DATA_VALID] = 1'b1;
`ifdef UART_RX_PARITY_EN
            rdata_d[DATA_PERR]  = head[8];
`endif
          end
        end
        REG_STATUS: begin
          rdata_d[DEPTH_LOG2:0] = fifo_count;
          rdata_d[STAT_EMPTY]   = fifo_empty;
          rdata_d[STAT_FULL]    = fifo_full;
          rdata_d[STAT_OVR]     = ovr_q;
          rdata_d[STAT_FERR]    = ferr_q;
`ifdef UART_RX_PARITY_EN
          rdata_d[STAT_PERR]    = perr_q;
`endif
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wait_high_q <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
      rdata_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
      rdata_q     <= rdata_d;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= par_err_d;
      perr_q      <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_mem.sv
// tb_uart_rx_mem: self-checking bench for uart_rx_mem at CLKS_PER_BIT=16,
// DEPTH_LOG2=4, against a queue-based model of the receive buffer and flags.
module tb_uart_rx_mem;

  localparam int CPB   = 16;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR      = 1'b1;
  localparam int STOP_OFS = 170;
`else
  localparam bit PAR      = 1'b0;
  localparam int STOP_OFS = 154;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [3:0]  writeb = 4'h0;
  logic        read = 1'b0;
  logic [5:0]  addr = 6'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  // Model: received entries {perr, byte} and sticky flags.
  logic [8:0] mq[$];
  bit m_ovr, m_ferr, m_perr;

  uart_rx_mem #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .rx(rx), .writeb(writeb), .read(read),
    .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(mq.size());
    s[16] = (mq.size() == 0);
    s[17] = (mq.size() == DEPTH);
    s[18] = m_ovr;
    s[19] = m_ferr;
    if (PAR) s[20] = m_perr;
    return s;
  endfunction

  function automatic logic [31:0] model_pop();
    logic [8:0]  e;
    logic [31:0] r;
    if (mq.size() == 0) return 32'h0;
    e = mq.pop_front();
    r = 32'h100 | 32'(e[7:0]);
    if (PAR) r[9] = e[8];
    return r;
  endfunction

  task automatic model_push(input logic [7:0] b, input bit pbad);
    if (PAR && pbad) m_perr = 1'b1;
    if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back({PAR && pbad, b});
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr = 0; m_ferr = 0; m_perr = 0;
  endtask

  task automatic drive_bit(input logic v);
    #1 rx = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit pbad);
    @(posedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ pbad);
    drive_bit(stop_v);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    read = 1'b1; addr = a;
    @(negedge clk);
    read = 1'b0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] v);
    @(negedge clk);
    writeb = 4'h1; addr = a; wdata = v;
    @(negedge clk);
    writeb = 4'h0; wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    do_reset();
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL reset_status got=%h exp=%h", d, e); end
    bus_read(6'd10, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h exp=%h", d, 32'h0); end
    bus_write(6'd3, 32'hffff_ffff);
    bus_read(6'd3, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL other_read got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    send_frame(8'h55, 1'b1, 1'b0);
    model_push(8'h55, 1'b0);
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL single_status got=%h exp=%h", d, e); end
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e || d !== 32'h155) begin bad++; $display("FAIL single_data got=%h exp=%h", d, e); end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL single_empty got=%h exp=%h", d, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    for (int i = 0; i < 18; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_push(8'(i), 1'b0);
    end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL ovf_status got=%h exp=%h", d, e); end
    for (int i = 0; i < 16; i++) begin
      e = model_pop();
      bus_read(6'd8, d);
      total++;
      if (d !== e) begin bad++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, e); end
    end
    bus_write(6'd10, 32'h1);
    m_ovr = 1'b0;
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL ovr_clear got=%h exp=%h", d, e); end
  endtask

  task automatic test_frame_error();
    logic [31:0] d, e;
    send_frame(8'ha5, 1'b0, 1'b0);
    m_ferr = 1'b1;
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL ferr_status got=%h exp=%h", d, e); end
    send_frame(8'h3c, 1'b1, 1'b0);
    model_push(8'h3c, 1'b0);
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL ferr_next got=%h exp=%h", d, e); end
    bus_write(6'd10, 32'h2);
    m_ferr = 1'b0;
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL ferr_clear got=%h exp=%h", d, e); end
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL glitch_data got=%h exp=%h", d, e); end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL glitch_status got=%h exp=%h", d, e); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d, e;
    logic [7:0]  a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    send_frame(a, 1'b1, 1'b0);
    model_push(a, 1'b0);
    fork
      send_frame(b, 1'b1, 1'b0);
      begin
        @(negedge rx);
        repeat (STOP_OFS) @(posedge clk);
        #1 read = 1'b1; addr = 6'd8;
        @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        d = rdata;
      end
    join
    e = model_pop();
    model_push(b, 1'b0);
    total++;
    if (d !== e) begin bad++; $display("FAIL pp_old got=%h exp=%h", d, e); end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL pp_count got=%h exp=%h", d, e); end
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL pp_new got=%h exp=%h", d, e); end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_push(b, 1'b0);
    end
    bus_write(6'd10, 32'h8);
    mq.delete();
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL flush_status got=%h exp=%h", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0);
      model_push(b, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        e = model_pop();
        bus_read(6'd8, d);
        total++;
        if (d !== e) begin bad++; $display("FAIL rand_data%0d got=%h exp=%h", i, d, e); end
      end
    end
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL rand_status got=%h exp=%h", d, e); end
    while (mq.size() != 0) begin
      e = model_pop();
      bus_read(6'd8, d);
      total++;
      if (d !== e) begin bad++; $display("FAIL rand_drain got=%h exp=%h", d, e); end
    end
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL rand_empty_read got=%h exp=%h", d, e); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [31:0] d, e;
    send_frame(8'h07, 1'b1, 1'b1);
    model_push(8'h07, 1'b1);
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL perr_status got=%h exp=%h", d, e); end
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e || d !== 32'h307) begin bad++; $display("FAIL perr_data got=%h exp=%h", d, e); end
    bus_write(6'd10, 32'h4);
    m_perr = 1'b0;
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL perr_clear got=%h exp=%h", d, e); end
  endtask
`endif

  task automatic test_reset_midframe();
    logic [31:0] d, e;
    logic [7:0]  b;
    send_frame(8'h9a, 1'b1, 1'b0);
    model_push(8'h9a, 1'b0);
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL mid_pre got=%h exp=%h", d, e); end
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; rx = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h exp=%h", rdata, 32'h0); end
    repeat (12 * CPB) @(posedge clk);
    e = model_status();
    bus_read(6'd9, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL mid_status got=%h exp=%h", d, e); end
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    model_push(b, 1'b0);
    e = model_pop();
    bus_read(6'd8, d);
    total++;
    if (d !== e) begin bad++; $display("FAIL mid_fresh got=%h exp=%h", d, e); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_frame_error();
    test_glitch();
    test_push_pop();
    test_flush();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
